// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: fetch FSM state type, reset PC / bubble defaults
// and the PC increment helper.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Sequential PC step; the 32-bit result wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry buffer that parks a fetched word and its PC+4 while the pipe is stalled.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic        consume,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc4,
    output logic [31:0] data,
    output logic [31:0] pc4,
    output logic        valid
);

    logic [31:0] data_r;
    logic [31:0] pc4_r;
    logic        valid_r;

    // Entry storage; clear beats load, load beats consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r  <= 32'h0000_0000;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            pc4_r   <= load_pc4;
            valid_r <= 1'b1;
        end else if (consume) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign data  = data_r;
    assign pc4   = pc4_r;
    assign valid = valid_r;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID stage: fetch FSM (REQ/HOLD/DROP), stall hold buffer, flush and branch redirect.
// Define PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nop,
    input  logic        IFID_flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_ID,
    output logic [31:0] pc4_ID,
    output logic        valid_ID
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    fetch_state_e state_r, state_nxt_s;
    logic [31:0]  pc_r, pc_nxt_s;
    logic [31:0]  addr_r, addr_nxt_s;
    logic         req_r;
    logic [31:0]  instr_r, instr_nxt_s;
    logic [31:0]  pc4_r, pc4_nxt_s;
    logic         valid_r, valid_nxt_s;
    logic         eff_flush_s, eff_redir_s;
    logic         hb_load_s, hb_clear_s, hb_consume_s;
    logic [31:0]  hb_data_s, hb_pc4_s;
    logic         hb_valid_s;

    assign eff_flush_s = IFID_flush & ~nop;
    assign eff_redir_s = branch_taken & ~nop;

    fetch_hold_buf u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (hb_load_s),
        .clear     (hb_clear_s),
        .consume   (hb_consume_s),
        .load_data (imem_rdata),
        .load_pc4  (pc_plus4(pc_r)),
        .data      (hb_data_s),
        .pc4       (hb_pc4_s),
        .valid     (hb_valid_s)
    );

    // Next-state logic: normal fetch flow first, then flush/redirect overrides.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        instr_nxt_s  = instr_r;
        pc4_nxt_s    = pc4_r;
        valid_nxt_s  = valid_r;
        hb_load_s    = 1'b0;
        hb_clear_s   = 1'b0;
        hb_consume_s = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (imem_ack && nop) begin
                    hb_load_s   = 1'b1;
                    pc_nxt_s    = pc_plus4(pc_r);
                    state_nxt_s = ST_HOLD;
                end else if (imem_ack) begin
                    instr_nxt_s = imem_rdata;
                    pc4_nxt_s   = pc_plus4(pc_r);
                    valid_nxt_s = 1'b1;
                    pc_nxt_s    = pc_plus4(pc_r);
                end else if (eff_flush_s || eff_redir_s) begin
                    // Address must stay put until the ack, so drain the wrong-path fetch.
                    state_nxt_s = ST_DROP;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (!nop) begin
                    instr_nxt_s  = hb_data_s;
                    pc4_nxt_s    = hb_pc4_s;
                    valid_nxt_s  = hb_valid_s;
                    hb_consume_s = 1'b1;
                    state_nxt_s  = ST_REQ;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
            end
        endcase
        if (eff_flush_s) begin
            instr_nxt_s = NOP_INSTR;
            pc4_nxt_s   = 32'h0000_0000;
            valid_nxt_s = 1'b0;
            hb_clear_s  = 1'b1;
        end else begin
            hb_clear_s  = 1'b0;
        end
        if (eff_redir_s) begin
            pc_nxt_s = branch_target;
        end else begin
            pc_nxt_s = pc_nxt_s;
        end
    end

    // A new request address is only taken when the FSM (re)enters REQ.
    assign addr_nxt_s = (state_nxt_s == ST_REQ) ? pc_nxt_s : addr_r;

    // Fetch FSM and IF/ID register; every output is driven straight from these flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_REQ;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            req_r   <= 1'b1;
            instr_r <= NOP_INSTR;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            addr_r  <= addr_nxt_s;
            req_r   <= (state_nxt_s != ST_HOLD);
            instr_r <= instr_nxt_s;
            pc4_r   <= pc4_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = addr_r;
    assign instr_ID  = instr_r;
    assign pc4_ID    = pc4_r;
    assign valid_ID  = valid_r;

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Free-running wrap-around counters of stall cycles and effective flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'h0000_0000;
            flush_cnt_r <= 32'h0000_0000;
        end else begin
            stall_cnt_r <= stall_cnt_r + {31'd0, nop};
            flush_cnt_r <= flush_cnt_r + {31'd0, eff_flush_s};
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus random stall/flush/ack traffic,
// all compared against a transaction-level reference model of the fetch stage.
module tb_if_id_stage;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, nop, IFID_flush, branch_taken, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, valid_ID;
    logic [31:0] imem_addr, instr_ID, pc4_ID;

    logic        w_reset, w_ack, w_zero;
    logic [31:0] w_rdata, w_zero32;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc4;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, w_stall, w_flush;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk(clk), .reset(reset), .nop(nop), .IFID_flush(IFID_flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_ID(instr_ID), .pc4_ID(pc4_ID), .valid_ID(valid_ID)
`ifdef PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(w_reset), .nop(w_zero), .IFID_flush(w_zero),
        .branch_taken(w_zero), .branch_target(w_zero32),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
        .imem_rdata(w_rdata), .instr_ID(w_instr), .pc4_ID(w_pc4), .valid_ID(w_valid)
`ifdef PERF_CNT_EN
        , .stall_cnt(w_stall), .flush_cnt(w_flush)
`endif
    );

    // Reference model: the memory's view (outstanding address, whether its data is dead),
    // a queue of parked words and the architectural IF/ID contents.
    typedef struct { logic [31:0] word; logic [31:0] pc4; } held_t;
    held_t       hold_q[$];
    logic        m_drop, m_req, m_valid;
    logic [31:0] m_pc, m_addr, m_instr, m_pc4, m_stall, m_flush, salt;

    task automatic squash();
        m_instr = NOP_WORD; m_pc4 = 32'h0; m_valid = 1'b0;
        hold_q.delete();
    endtask

    task automatic model_step(input logic rst, input logic n, input logic fl, input logic br,
                              input logic [31:0] tgt, input logic ack, input logic [31:0] rd);
        logic eff_fl, eff_br;
        eff_fl = fl && !n;
        eff_br = br && !n;
        if (rst) begin
            m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b1; m_drop = 1'b0;
            m_instr = NOP_WORD; m_pc4 = 32'h0; m_valid = 1'b0;
            m_stall = 32'h0; m_flush = 32'h0;
            hold_q.delete();
        end else begin
            if (n) m_stall = m_stall + 32'd1;
            if (eff_fl) m_flush = m_flush + 32'd1;
            if (hold_q.size() != 0) begin
                if (!n) begin
                    if (eff_fl) squash();
                    else begin
                        m_instr = hold_q[0].word; m_pc4 = hold_q[0].pc4; m_valid = 1'b1;
                    end
                    hold_q.delete();
                    if (eff_br) m_pc = tgt;
                    m_addr = m_pc; m_req = 1'b1;
                end
            end else if (m_drop) begin
                if (eff_fl) squash();
                if (eff_br) m_pc = tgt;
                if (ack) begin m_drop = 1'b0; m_addr = m_pc; end
            end else if (ack && n) begin
                hold_q.push_back('{word: rd, pc4: m_addr + 32'd4});
                m_pc = m_addr + 32'd4; m_req = 1'b0;
            end else if (ack) begin
                if (eff_fl) squash();
                else begin m_instr = rd; m_pc4 = m_addr + 32'd4; m_valid = 1'b1; end
                m_pc = eff_br ? tgt : m_addr + 32'd4;
                m_addr = m_pc;
            end else if (eff_fl || eff_br) begin
                if (eff_fl) squash();
                if (eff_br) m_pc = tgt;
                m_drop = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("req", {31'd0, imem_req}, {31'd0, m_req});
        chk("addr", imem_addr, m_addr);
        chk("instr", instr_ID, m_instr);
        chk("pc4", pc4_ID, m_pc4);
        chk("valid", {31'd0, valid_ID}, {31'd0, m_valid});
`ifdef PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
`endif
    endtask

    task automatic tick(input logic rst, input logic n, input logic fl, input logic br,
                        input logic [31:0] tgt, input logic ack);
        reset = rst; nop = n; IFID_flush = fl; branch_taken = br; branch_target = tgt;
        imem_ack = ack;
        imem_rdata = ack ? (m_addr ^ salt) : 32'hDEAD_BEEF;
        model_step(rst, n, fl, br, tgt, ack, imem_rdata);
        @(posedge clk);
        #1;
        check_model();
    endtask

    logic        r_rst, r_nop, r_fl, r_br, r_ack;
    logic [31:0] r_tgt;

    initial begin
        salt = 32'h0; m_addr = 32'h0;
        w_reset = 1'b1; w_ack = 1'b0; w_rdata = 32'h0; w_zero = 1'b0; w_zero32 = 32'h0;

        // Reset state, then back-to-back acks with rdata = address.
        tick(1, 0, 0, 0, 32'h0, 1);
        tick(1, 0, 0, 0, 32'h0, 0);
        chk("rst_instr", instr_ID, 32'h0000_0000);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        tick(0, 0, 0, 0, 32'h0, 1);
        chk("seq0", instr_ID, 32'h0000_0000);
        chk("seq0_valid", {31'd0, valid_ID}, 32'd1);
        tick(0, 0, 0, 0, 32'h0, 1);
        chk("seq4", instr_ID, 32'h0000_0004);
        tick(0, 0, 0, 0, 32'h0, 1);
        chk("seq8", instr_ID, 32'h0000_0008);
        tick(0, 0, 0, 0, 32'h0, 1);

        // Three-cycle stall across the acked fetch at 0x10.
        tick(0, 1, 0, 0, 32'h0, 1);
        chk("stall_hold", instr_ID, 32'h0000_000C);
        tick(0, 1, 0, 0, 32'h0, 0);
        tick(0, 1, 0, 0, 32'h0, 0);
        chk("stall_hold3", instr_ID, 32'h0000_000C);
        tick(0, 0, 0, 0, 32'h0, 0);
        chk("release_instr", instr_ID, 32'h0000_0010);
        chk("release_pc4", pc4_ID, 32'h0000_0014);
        tick(0, 0, 0, 0, 32'h0, 0);
        tick(0, 0, 0, 0, 32'h0, 1);
        chk("after_release", instr_ID, 32'h0000_0014);

        // Flush + taken branch while the fetch at 0x18 is still outstanding.
        tick(0, 0, 1, 1, 32'h100, 0);
        chk("flush_valid", {31'd0, valid_ID}, 32'd0);
        chk("drop_addr", imem_addr, 32'h0000_0018);
        tick(0, 0, 0, 0, 32'h0, 0);
        tick(0, 0, 0, 0, 32'h0, 1);
        chk("redirect_addr", imem_addr, 32'h0000_0100);
        chk("dropped_valid", {31'd0, valid_ID}, 32'd0);
        tick(0, 0, 0, 0, 32'h0, 1);
        chk("target_instr", instr_ID, 32'h0000_0100);

        // Flush under stall is ignored; once the stall lifts it takes effect.
        tick(0, 1, 1, 1, 32'h200, 0);
        chk("stall_flush_valid", {31'd0, valid_ID}, 32'd1);
        tick(0, 0, 1, 1, 32'h200, 0);
        chk("late_flush_valid", {31'd0, valid_ID}, 32'd0);
        tick(0, 0, 0, 0, 32'h0, 1);
        chk("late_redirect", imem_addr, 32'h0000_0200);

        // Counter scenario: three stall cycles, one effective flush.
        tick(1, 0, 0, 0, 32'h0, 0);
        tick(0, 1, 0, 0, 32'h0, 0);
        tick(0, 1, 0, 0, 32'h0, 0);
        tick(0, 1, 0, 0, 32'h0, 0);
        tick(0, 0, 1, 0, 32'h0, 0);
`ifdef PERF_CNT_EN
        chk("stall_cnt3", stall_cnt, 32'd3);
        chk("flush_cnt1", flush_cnt, 32'd1);
`endif
        tick(0, 0, 0, 0, 32'h0, 1);

        // Random traffic against the model.
        salt = 32'h5A5A_0000;
        for (int i = 0; i < 800; i++) begin
            r_rst = ($urandom_range(99) < 2);
            r_nop = ($urandom_range(99) < 25);
            r_fl  = ($urandom_range(99) < 12);
            r_br  = r_fl && ($urandom_range(1) == 1);
            r_tgt = $urandom() & 32'hFFFF_FFFC;
            r_ack = m_req && ($urandom_range(99) < 55);
            tick(r_rst, r_nop, r_fl, r_br, r_tgt, r_ack);
        end

        // PC wrap with RESET_PC = 0xFFFF_FFFC.
        @(posedge clk); #1;
        chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_rst_req", {31'd0, w_req}, 32'd1);
        w_reset = 1'b0; w_ack = 1'b1; w_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        chk("wrap_addr2", w_addr, 32'h0000_0000);
        chk("wrap_pc4", w_pc4, 32'h0000_0000);
        chk("wrap_instr", w_instr, 32'h1234_5678);
        w_rdata = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        chk("wrap_addr3", w_addr, 32'h0000_0004);
        chk("wrap_pc4_2", w_pc4, 32'h0000_0004);
`ifdef PERF_CNT_EN
        chk("wrap_stall0", w_stall, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
